dataflow_ctrl: RTL and testbench

//   Multicycle controller for the 64-bit dataflow datapath: register file (32x64, sync read),

---
 rtl/dataflow_ctrl.sv | 156 +++++++++++++++
 tb/tb_dataflow_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dataflow_ctrl.sv
// Multicycle controller for the 64-bit dataflow datapath (regfile, adder, Mux1/Mux2, data memory).
// Sequences ADD/SUB/ADDI/LD/ST over a valid/ready command port and counts retired commands.
module dataflow_ctrl #(
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_ra,
  input  logic [4:0]       cmd_rb,
  input  logic [4:0]       cmd_rw,
  input  logic [IMM_W-1:0] cmd_imm,
  input  logic [63:0]      soma,
  output logic [4:0]       rf_ra,
  output logic [4:0]       rf_rb,
  output logic [4:0]       rf_rw,
  output logic             rf_we,
  output logic [63:0]      imm_c,
  output logic             sel_mux1,
  output logic             sinal,
  output logic [5:0]       mem_ads,
  output logic             mem_we,
  output logic             sel_mux2,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [15:0]      retired
);

  localparam int unsigned DATA_W = 64;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_LD   = 3'd3;
  localparam logic [2:0] OP_ST   = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [2:0]       op_q;
  logic [4:0]       ra_q, rb_q, rw_q;
  logic [IMM_W-1:0] imm_q;
  logic [15:0]      retired_q;

  logic accept;
  logic is_alu;
  logic in_range;
  logic retire;

  assign accept   = cmd_valid && (state == S_IDLE);
  assign is_alu   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADDI);
  // Signed 64-bit range check: non-negative and below the memory depth
  assign in_range = !soma[DATA_W-1] && (soma < DATA_W'(MEM_DEPTH));
  assign retire   = done && !err;

  // State, latched command fields and retired counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rw_q      <= '0;
      imm_q     <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= cmd_op;
        ra_q  <= cmd_ra;
        rb_q  <= cmd_rb;
        rw_q  <= cmd_rw;
        imm_q <= cmd_imm;
      end
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  // Next state and control decode; every output is held at 0 while rst is high
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    rf_ra     = '0;
    rf_rb     = '0;
    rf_rw     = '0;
    rf_we     = 1'b0;
    imm_c     = '0;
    sel_mux1  = 1'b0;
    sinal     = 1'b0;
    mem_ads   = '0;
    mem_we    = 1'b0;
    sel_mux2  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    retired   = '0;

    case (state)
      S_IDLE: if (cmd_valid) state_nxt = (cmd_op <= OP_ST) ? S_READ : S_ERR;
      S_READ: state_nxt = is_alu ? S_WB : S_ADDR;
      S_ADDR: state_nxt = ((op_q == OP_LD) && in_range) ? S_WB : S_IDLE;
      S_WB:   state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (!rst) begin
      cmd_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      rf_ra     = ra_q;
      rf_rb     = rb_q;
      rf_rw     = rw_q;
      imm_c     = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
      retired   = retired_q;

      if ((state == S_READ) || (state == S_ADDR) || (state == S_WB)) begin
        sel_mux1 = (op_q == OP_ADD) || (op_q == OP_SUB);
        sinal    = (op_q == OP_SUB);
      end

      case (state)
        S_ADDR: begin
          mem_ads = soma[5:0];
          if (op_q == OP_ST) begin
            mem_we = in_range;
            done   = 1'b1;
            err    = !in_range;
          end else if (!in_range) begin
            done = 1'b1;
            err  = 1'b1;
          end
        end
        S_WB: begin
          rf_we    = 1'b1;
          done     = 1'b1;
          sel_mux2 = is_alu;
          if (!is_alu) mem_ads = soma[5:0];
        end
        S_ERR: begin
          done = 1'b1;
          err  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dataflow_ctrl.sv
// Bench for dataflow_ctrl: behavioural datapath around the controller, directed commands,
// and a scoreboard monitor that checks each completed command against hand-computed results.
module tb_dataflow_ctrl;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_ra, cmd_rb, cmd_rw;
  logic [15:0] cmd_imm;
  logic [63:0] soma;
  logic [4:0]  rf_ra, rf_rb, rf_rw;
  logic        rf_we, sel_mux1, sinal, mem_we, sel_mux2, done, err, busy;
  logic [63:0] imm_c;
  logic [5:0]  mem_ads;
  logic [15:0] retired;

  dataflow_ctrl #(.IMM_W(16), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_imm(cmd_imm),
    .soma(soma), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rw(rf_rw), .rf_we(rf_we), .imm_c(imm_c),
    .sel_mux1(sel_mux1), .sinal(sinal), .mem_ads(mem_ads), .mem_we(mem_we), .sel_mux2(sel_mux2),
    .done(done), .err(err), .busy(busy), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: sync-read regfile (frozen while rf_we), adder, Mux1/Mux2, async-read memory
  logic [63:0] rf [32];
  logic [63:0] mem [64];
  logic [63:0] douta = '0, doutb = '0, opb;
  assign opb  = sel_mux1 ? doutb : imm_c;
  assign soma = sinal ? (douta - opb) : (douta + opb);

  always @(posedge clk) begin
    if (!rf_we) begin
      douta <= rf[rf_ra];
      doutb <= rf[rf_rb];
    end
    if (rf_we) rf[rf_rw] <= sel_mux2 ? soma : mem[mem_ads];
    if (mem_we) mem[mem_ads] <= doutb;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         acc;
    int         lat;
    logic       err;
    int         rfwe;
    int         memwe;
    int         ret;
    logic       chk_ctl;
    logic [2:0] ctl;
    logic       chk_ads;
    logic [5:0] ads;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(int lat, logic e, int rfwe, int memwe, int ret,
                              logic chk_ctl, logic [2:0] ctl, logic chk_ads, logic [5:0] ads);
    exp_t x;
    x.acc = 0; x.lat = lat; x.err = e; x.rfwe = rfwe; x.memwe = memwe; x.ret = ret;
    x.chk_ctl = chk_ctl; x.ctl = ctl; x.chk_ads = chk_ads; x.ads = ads;
    return x;
  endfunction

  // Monitor: tally write strobes per command and score each done pulse
  int         n_rfwe = 0, n_memwe = 0;
  logic [2:0] cap_ctl = '0;
  logic [5:0] cap_ads = '0;
  exp_t       me;

  always @(negedge clk) begin
    if (rst) begin
      n_rfwe = 0;
      n_memwe = 0;
    end else begin
      if (rf_we) begin
        n_rfwe++;
        cap_ctl = {sel_mux1, sinal, sel_mux2};
        cap_ads = mem_ads;
      end
      if (mem_we) begin
        n_memwe++;
        cap_ads = mem_ads;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          me = sb.pop_front();
          chk("err", 64'(err), 64'(me.err));
          chk("latency", 64'(cyc - me.acc), 64'(me.lat));
          chk("rf_we_cycles", 64'(n_rfwe), 64'(me.rfwe));
          chk("mem_we_cycles", 64'(n_memwe), 64'(me.memwe));
          chk("retired_at_done", 64'(retired), 64'(me.ret));
          chk("busy_at_done", 64'(busy), 64'(1));
          if (me.chk_ctl) chk("ctl_mux1_sinal_mux2", 64'(cap_ctl), 64'(me.ctl));
          if (me.chk_ads) chk("mem_ads", 64'(cap_ads), 64'(me.ads));
        end
        n_rfwe = 0;
        n_memwe = 0;
      end
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Present a command at a negedge, wait for acceptance, return at the following negedge
  task automatic issue(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rw, input logic [15:0] imm, input bit push,
                       input exp_t e, output int acc);
    int n;
    exp_t x;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rw = rw; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 64'(cmd_ready), 64'(1));
      finish_run();
    end
    acc = cyc;
    x = e;
    x.acc = cyc;
    if (push) sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));
  endtask

  int a0, a1;
  exp_t none;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rf[1] = 64'd1;
    mem[0] = 64'd45;
    mem[1] = 64'd11;
    none = mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 6'd0);

    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rw = '0; cmd_imm = '0;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 64'(cmd_ready), 64'(1));
    chk("post_reset_busy", 64'(busy), 64'(0));
    chk("post_reset_retired", 64'(retired), 64'(0));
    @(negedge clk);

    // ADD r2 = r1 + r1
    issue(3'b000, 5'd1, 5'd1, 5'd2, 16'd0, 1, mk(2, 0, 1, 0, 0, 1, 3'b101, 0, 6'd0), a0);
    drain();
    // LD r3 = mem[r0 + 1]
    issue(3'b011, 5'd0, 5'd0, 5'd3, 16'd1, 1, mk(3, 0, 1, 0, 1, 1, 3'b000, 1, 6'd1), a0);
    drain();
    // ST mem[r1 - 1] = r1
    issue(3'b100, 5'd1, 5'd1, 5'd0, 16'hFFFF, 1, mk(2, 0, 0, 1, 2, 0, 3'b000, 1, 6'd0), a0);
    drain();
    // Out-of-range LD (40) and ST (-1)
    issue(3'b011, 5'd0, 5'd0, 5'd4, 16'd40, 1, mk(2, 1, 0, 0, 3, 0, 3'b000, 0, 6'd0), a0);
    drain();
    issue(3'b100, 5'd0, 5'd1, 5'd0, 16'hFFFF, 1, mk(2, 1, 0, 0, 3, 0, 3'b000, 0, 6'd0), a0);
    drain();
    // Illegal op, then SUB r5 = r3 - r2 presented back-to-back
    issue(3'b111, 5'd1, 5'd1, 5'd9, 16'd0, 1, mk(1, 1, 0, 0, 3, 0, 3'b000, 0, 6'd0), a0);
    issue(3'b001, 5'd3, 5'd2, 5'd5, 16'd0, 1, mk(2, 0, 1, 0, 3, 1, 3'b111, 0, 6'd0), a1);
    chk("back_to_back_accept", 64'(a1 - a0), 64'(2));
    drain();
    // ADDI r6 = r3 - 20; ADDI r0 = r1 + 5
    issue(3'b010, 5'd3, 5'd0, 5'd6, 16'hFFEC, 1, mk(2, 0, 1, 0, 4, 1, 3'b001, 0, 6'd0), a0);
    drain();
    issue(3'b010, 5'd1, 5'd0, 5'd0, 16'd5, 1, mk(2, 0, 1, 0, 5, 1, 3'b001, 0, 6'd0), a0);
    drain();
    // LD r7 = mem[r0 - 5]; ST mem[r1 + 30] = r5 (last word); LD at r1 + 31 = 32 is out of range
    issue(3'b011, 5'd0, 5'd0, 5'd7, 16'hFFFB, 1, mk(3, 0, 1, 0, 6, 1, 3'b000, 1, 6'd1), a0);
    drain();
    issue(3'b100, 5'd1, 5'd5, 5'd0, 16'd30, 1, mk(2, 0, 0, 1, 7, 0, 3'b000, 1, 6'd31), a0);
    drain();
    issue(3'b011, 5'd1, 5'd0, 5'd4, 16'd31, 1, mk(2, 1, 0, 0, 8, 0, 3'b000, 0, 6'd0), a0);
    drain();
    chk("retired_before_reset", 64'(retired), 64'(8));

    // Reset during ADDR of an in-range ST: the write must be suppressed
    issue(3'b100, 5'd1, 5'd2, 5'd0, 16'hFFFF, 0, none, a0);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_mem_we", 64'(mem_we), 64'(0));
    chk("reset_cmd_ready_mid", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_retired", 64'(retired), 64'(0));
    chk("abort_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);

    // ADD r8 = r1 + r1 after reset
    issue(3'b000, 5'd1, 5'd1, 5'd8, 16'd0, 1, mk(2, 0, 1, 0, 0, 1, 3'b101, 0, 6'd0), a0);
    drain();
    @(negedge clk);

    chk("r2", rf[2], 64'd2);
    chk("r3", rf[3], 64'd11);
    chk("r4_untouched", rf[4], 64'd0);
    chk("r5", rf[5], 64'd9);
    chk("r6", rf[6], 64'hFFFF_FFFF_FFFF_FFF7);
    chk("r0_written", rf[0], 64'd6);
    chk("r7", rf[7], 64'd11);
    chk("r8", rf[8], 64'd2);
    chk("r9_illegal_untouched", rf[9], 64'd0);
    chk("mem0", mem[0], 64'd1);
    chk("mem31", mem[31], 64'd9);
    chk("mem63_untouched", mem[63], 64'd0);
    chk("retired_final", 64'(retired), 64'(1));
    finish_run();
  end

endmodule
